seg7_sniffer: RTL and testbench
===============================

Name: seg7_sniffer

Overview:
- Receive side of the 4-digit multiplexed 7-segment display interface: it watches the active-low anode and segment lines driven by a display scanner and reconstructs the 16-bit hex value being shown.
- Used for loopback self-test of the display path and for capturing another board's display over a header.
- Filters scan ghosting with a stability counter, decodes each digit back to a nibble, flags blank or illegal glyphs, and publishes one frame once all four digits have been seen.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is accepted (≥2).
- TIMEOUT_CYCLES, 1048576, cycles allowed to collect all four digits before the partial frame is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- an  in  4  anode lines, active-low; an[i]=0 selects digit i (digit 0 = least significant nibble).
- seg  in  7  segment lines {CG,CF,CE,CD,CC,CB,CA}, active-low (0 = lit).
- hex_value  out  16  last completed frame, digit i in bits [4i+3:4i].
- blank_mask  out  4  bit i set if digit i was blank (seg=7'h7F) in the last frame.
- bad_mask  out  4  bit i set if digit i was an illegal pattern in the last frame.
- frame_valid  out  1  one-cycle pulse when hex_value/masks update.
- timeout  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset:
  - All outputs are 0.
  - seen[3:0], counters, synchronizer flops and digit buffers are cleared.
  - FSM enters WAIT.
  - Reset asserted mid-frame discards the partial frame with no pulse.
- Input path:
  - an and seg each pass through a 2-flop synchronizer.
  - All logic below uses the synchronized values (2-cycle input latency).
- Stability:
  - stab_cnt increments while the synchronized {an,seg} equals the previous cycle's value, saturating at STABLE_CYCLES.
  - Any change resets stab_cnt to 1 and returns the FSM to WAIT.
- FSM:
  - WAIT → CAPTURE when stab_cnt reaches STABLE_CYCLES and an has exactly one bit low.
  - If an is 4'hF or has more than one bit low, the sample is ignored and the FSM stays in WAIT.
  - CAPTURE (one cycle):
    - Writes the decoded nibble into buf[i] and sets seen[i].
    - Sets or clears blank_buf[i] and bad_buf[i] according to the decode.
    - Then goes to HOLD.
  - HOLD: holds until the input changes, then goes to WAIT. Exactly one capture happens per dwell.
- Decode, seg→nibble; all other patterns are illegal (nibble 0, bad bit set):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - 7F is blank: nibble 0, blank bit set, bad bit clear.
- Digit revisits: recapturing a digit already in seen overwrites its buffer entry (latest value wins).
- Frame completion:
  - The cycle after seen becomes 4'hF, hex_value, blank_mask and bad_mask load from the buffers.
  - frame_valid pulses for 1 cycle and seen clears.
  - Outputs hold between frames.
- Timeout:
  - tmo_cnt runs while seen≠0 and resets on every frame completion.
  - Reaching TIMEOUT_CYCLES clears seen, pulses timeout for 1 cycle, and leaves outputs unchanged.
  - If the timeout and the completing capture occur in the same cycle, completion wins and no timeout pulse is issued.
- Counter widths are sized by $clog2 of their parameter + 1. No wrap-around is allowed.

Test Plan:
- Scan value 16'hB7E0 (seg 03/78/06/40 on digits 3..0), 8 cycles per digit, STABLE_CYCLES=4 → one frame_valid, hex_value=16'hB7E0, blank_mask=0, bad_mask=0.
- Same scan with 2-cycle glitches of seg=7'h00 at each digit transition → no captures of 8; hex_value=16'hB7E0.
- Digit 2 driven with 7F and digit 1 with 7'h55, others 1 → frame_valid, hex_value=16'h1001, blank_mask=4'b0100, bad_mask=4'b0010.
- TIMEOUT_CYCLES=64, scan only digits 0–2, then hold an=4'hF → timeout pulses at 64 cycles after first capture; hex_value unchanged; frame_valid never pulses.
- Assert rst after 3 digits captured, release, scan a full 16'h1234 → hex_value=16'h1234 and exactly one frame_valid after release.
- Hold a single digit stable 1000 cycles (an=4'hE, seg=7'h30), then complete the other digits → digit 0 captured once, nibble 3.

Source files
------------

// File: rtl/seg7_sniffer.sv
// Receive side of a 4-digit multiplexed 7-segment display: watches the active-low
// anode/segment lines and rebuilds the 16-bit hex value being shown.
module seg7_sniffer #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] hex_value,
  output logic [3:0]  blank_mask,
  output logic [3:0]  bad_mask,
  output logic        frame_valid,
  output logic        timeout
);
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_CAPTURE, ST_HOLD} state_t;

  logic [3:0]      r_anMeta, r_anSync, r_anPrev;
  logic [6:0]      r_segMeta, r_segSync, r_segPrev;
  logic [SW-1:0]   r_stab;
  state_t          r_state;
  logic            r_changed;
  logic [3:0]      r_capAn;
  logic [6:0]      r_capSeg;
  logic [3:0][3:0] r_buf;
  logic [3:0]      r_blankBuf, r_badBuf, r_seen;
  logic [TW-1:0]   r_tmo;

  logic            w_change, w_prevValid, w_startCap;
  logic [3:0]      w_nib;
  logic            w_blank, w_bad;
  logic [1:0]      w_capIdx;
  logic [3:0]      w_capBit, w_seenCap;
  logic            w_complete, w_tmoHit;
  logic [TW-1:0]   w_tmoInc;

  assign w_change    = {r_anSync, r_segSync} != {r_anPrev, r_segPrev};
  assign w_prevValid = $onehot(~r_anPrev);
  // r_changed lets HOLD start a new capture straight away when the next dwell is already stable.
  assign w_startCap  = (r_stab == STAB_MAX) && w_prevValid &&
                       ((r_state == ST_WAIT) || ((r_state == ST_HOLD) && r_changed));
  assign w_capBit    = ~r_capAn;
  assign w_seenCap   = (r_state == ST_CAPTURE) ? (r_seen | w_capBit) : r_seen;
  assign w_complete  = (r_seen == 4'hF);
  assign w_tmoInc    = r_tmo + TW'(1);
  assign w_tmoHit    = (r_seen != 4'h0) && !w_complete && (w_tmoInc == TMO_MAX) &&
                       (w_seenCap != 4'hF);

  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    w_bad   = 1'b0;
    case (r_capSeg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_blank = 1'b1;
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_capIdx = 2'd0;
    case (r_capAn)
      4'b1101: w_capIdx = 2'd1;
      4'b1011: w_capIdx = 2'd2;
      4'b0111: w_capIdx = 2'd3;
      default: w_capIdx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anMeta  <= '0;
      r_anSync  <= '0;
      r_anPrev  <= '0;
      r_segMeta <= '0;
      r_segSync <= '0;
      r_segPrev <= '0;
      r_stab    <= '0;
    end else begin
      r_anMeta  <= an;
      r_anSync  <= r_anMeta;
      r_anPrev  <= r_anSync;
      r_segMeta <= seg;
      r_segSync <= r_segMeta;
      r_segPrev <= r_segSync;
      if (w_change)
        r_stab <= SW'(1);
      else if (r_stab != STAB_MAX)
        r_stab <= r_stab + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_WAIT;
      r_changed <= 1'b0;
      r_capAn   <= 4'hF;
      r_capSeg  <= '0;
    end else begin
      case (r_state)
        ST_WAIT, ST_HOLD: begin
          if (w_startCap) begin
            r_state  <= ST_CAPTURE;
            r_capAn  <= r_anPrev;
            r_capSeg <= r_segPrev;
          end else if ((r_state == ST_HOLD) && (r_changed || w_change)) begin
            r_state <= ST_WAIT;
          end
        end
        ST_CAPTURE: r_state <= ST_HOLD;
        default:    r_state <= ST_WAIT;
      endcase
      r_changed <= w_startCap ? w_change : (r_changed | w_change);
    end
  end

  // Completion takes priority over timeout, so a frame finished on the deadline still publishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= '0;
      r_blankBuf  <= '0;
      r_badBuf    <= '0;
      r_seen      <= '0;
      r_tmo       <= '0;
      hex_value   <= '0;
      blank_mask  <= '0;
      bad_mask    <= '0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      if (r_state == ST_CAPTURE) begin
        r_buf[w_capIdx]      <= w_nib;
        r_blankBuf[w_capIdx] <= w_blank;
        r_badBuf[w_capIdx]   <= w_bad;
      end
      if (w_complete) begin
        hex_value   <= r_buf;
        blank_mask  <= r_blankBuf;
        bad_mask    <= r_badBuf;
        frame_valid <= 1'b1;
        r_seen      <= '0;
        r_tmo       <= '0;
      end else if (w_tmoHit) begin
        timeout <= 1'b1;
        r_seen  <= '0;
        r_tmo   <= '0;
      end else begin
        r_seen <= w_seenCap;
        r_tmo  <= (r_seen == 4'h0) ? '0 : w_tmoInc;
      end
    end
  end
endmodule

// File: tb/tb_seg7_sniffer.sv
// Bench for seg7_sniffer: a run-length/latency model of the display sniffer checked
// against the DUT every cycle, plus literal expectations for each scenario.
module tb_seg7_sniffer;
  localparam int S = 4;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] hex_value;
  logic [3:0]  blank_mask, bad_mask;
  logic        frame_valid, timeout;

  seg7_sniffer #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .hex_value(hex_value), .blank_mask(blank_mask), .bad_mask(bad_mask),
    .frame_valid(frame_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errCount = 0;
  int checkCount = 0;
  int edgeCnt = 0;

  logic [10:0] lastRaw = '0;
  int          runLen = 0;
  logic        dlV [4] = '{default: 1'b0};
  logic [3:0]  dlAn [4] = '{default: 4'hF};
  logic [6:0]  dlSeg [4] = '{default: 7'h7F};
  logic [3:0]  mSeen = '0, mBlankB = '0, mBadB = '0, mPre = '0;
  logic [3:0]  mNib [4] = '{default: 4'h0};
  logic [15:0] expHex = '0;
  logic [3:0]  expBlank = '0, expBad = '0;
  logic        expFv = 1'b0, expTmo = 1'b0;
  logic        mFire = 1'b0, mIsBlank = 1'b0, mIsBad = 1'b0;
  logic [3:0]  mFireAn = 4'hF, mNibTmp = '0;
  logic [6:0]  mFireSeg = '0;
  int          mDigit = 0, firstCap = 0;
  int          capCount [4] = '{default: 0};
  int          dutFv = 0, dutTmo = 0, lastTmoEdge = 0;

  function automatic int zeroCount(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic int digitOf(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] anOf(input int d);
    logic [3:0] m = 4'hF;
    m[d] = 1'b0;
    return m;
  endfunction

  // A digit is taken once per run of identical raw samples, when the run reaches S;
  // the synchronizer and stability check put the buffer write 4 edges after that sample.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lastRaw = '0; runLen = 0;
      for (int i = 0; i < 4; i++) begin dlV[i] = 1'b0; mNib[i] = 4'h0; end
      mSeen = '0; mBlankB = '0; mBadB = '0;
      expHex = '0; expBlank = '0; expBad = '0; expFv = 1'b0; expTmo = 1'b0;
    end else begin
      edgeCnt++;
      if ({an, seg} == lastRaw) runLen++; else runLen = 1;
      lastRaw  = {an, seg};
      mFire    = dlV[3];
      mFireAn  = dlAn[3];
      mFireSeg = dlSeg[3];
      for (int i = 3; i > 0; i--) begin
        dlV[i] = dlV[i-1]; dlAn[i] = dlAn[i-1]; dlSeg[i] = dlSeg[i-1];
      end
      dlV[0] = (runLen == S) && (zeroCount(an) == 1);
      dlAn[0] = an;
      dlSeg[0] = seg;
      expFv = 1'b0;
      expTmo = 1'b0;
      mPre = mSeen;
      if (mPre == 4'hF) begin
        expHex   = {mNib[3], mNib[2], mNib[1], mNib[0]};
        expBlank = mBlankB;
        expBad   = mBadB;
        expFv    = 1'b1;
        mSeen    = '0;
      end else begin
        if (mFire) begin
          mDigit = digitOf(mFireAn);
          mNibTmp = 4'h0; mIsBlank = 1'b0; mIsBad = 1'b1;
          if (mFireSeg == 7'h7F) begin
            mIsBlank = 1'b1; mIsBad = 1'b0;
          end else begin
            for (int g = 0; g < 16; g++)
              if (glyph[g] == mFireSeg) begin mNibTmp = 4'(g); mIsBad = 1'b0; end
          end
          mNib[mDigit] = mNibTmp;
          mBlankB[mDigit] = mIsBlank;
          mBadB[mDigit] = mIsBad;
          mSeen[mDigit] = 1'b1;
          capCount[mDigit]++;
          if (mPre == 4'h0) firstCap = edgeCnt;
        end
        if ((mPre != 4'h0) && (edgeCnt == firstCap + T) && (mSeen != 4'hF)) begin
          expTmo = 1'b1;
          mSeen = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkCount++;
    if ({hex_value, blank_mask, bad_mask, frame_valid, timeout} !==
        {expHex, expBlank, expBad, expFv, expTmo}) begin
      errCount++;
      $display("[TB] FAIL cycle %0d outputs: got hex=%h blank=%b bad=%b fv=%b tmo=%b, want hex=%h blank=%b bad=%b fv=%b tmo=%b",
               edgeCnt, hex_value, blank_mask, bad_mask, frame_valid, timeout,
               expHex, expBlank, expBad, expFv, expTmo);
    end
    if (frame_valid === 1'b1) dutFv++;
    if (timeout === 1'b1) begin dutTmo++; lastTmoEdge = edgeCnt; end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles);
    an = a;
    seg = s;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  initial begin
    int fv0, tm0, start, cap0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("reset_hex", int'(hex_value), 0);
    checkOutput("reset_masks", int'({blank_mask, bad_mask}), 0);
    checkOutput("reset_pulses", int'({frame_valid, timeout}), 0);

    $display("[TB] scan B7E0");
    fv0 = dutFv;
    applyStimulus(anOf(3), 7'h03, 8);
    applyStimulus(anOf(2), 7'h78, 8);
    applyStimulus(anOf(1), 7'h06, 8);
    applyStimulus(anOf(0), 7'h40, 8);
    applyStimulus(4'hF, 7'h7F, 12);
    checkOutput("t1_frames", dutFv - fv0, 1);
    checkOutput("t1_hex", int'(hex_value), 16'hB7E0);
    checkOutput("t1_masks", int'({blank_mask, bad_mask}), 0);

    $display("[TB] scan B7E0 with transition glitches");
    fv0 = dutFv;
    applyStimulus(anOf(3), 7'h03, 8);
    applyStimulus(anOf(2), 7'h00, 2);
    applyStimulus(anOf(2), 7'h78, 6);
    applyStimulus(anOf(1), 7'h00, 2);
    applyStimulus(anOf(1), 7'h06, 6);
    applyStimulus(anOf(0), 7'h00, 2);
    applyStimulus(anOf(0), 7'h40, 6);
    applyStimulus(4'hF, 7'h7F, 12);
    checkOutput("t2_frames", dutFv - fv0, 1);
    checkOutput("t2_hex", int'(hex_value), 16'hB7E0);
    checkOutput("t2_bad", int'(bad_mask), 0);

    $display("[TB] blank and illegal glyphs");
    fv0 = dutFv;
    applyStimulus(anOf(3), 7'h79, 8);
    applyStimulus(anOf(2), 7'h7F, 8);
    applyStimulus(anOf(1), 7'h55, 8);
    applyStimulus(anOf(0), 7'h79, 8);
    applyStimulus(4'hF, 7'h7F, 12);
    checkOutput("t3_frames", dutFv - fv0, 1);
    checkOutput("t3_hex", int'(hex_value), 16'h1001);
    checkOutput("t3_blank", int'(blank_mask), 4'b0100);
    checkOutput("t3_bad", int'(bad_mask), 4'b0010);

    $display("[TB] partial frame timeout");
    fv0 = dutFv; tm0 = dutTmo; start = edgeCnt;
    applyStimulus(anOf(0), 7'h40, 8);
    applyStimulus(anOf(1), 7'h79, 8);
    applyStimulus(anOf(2), 7'h24, 8);
    applyStimulus(4'hF, 7'h7F, 100);
    checkOutput("t4_timeouts", dutTmo - tm0, 1);
    checkOutput("t4_frames", dutFv - fv0, 0);
    checkOutput("t4_hex", int'(hex_value), 16'h1001);
    checkOutput("t4_tmo_edge", lastTmoEdge - start, 72);

    $display("[TB] reset mid-frame then scan 1234");
    applyStimulus(anOf(0), 7'h19, 8);
    applyStimulus(anOf(1), 7'h30, 8);
    applyStimulus(anOf(2), 7'h24, 8);
    rst = 1'b1;
    an = 4'hF;
    seg = 7'h7F;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("t5_reset_hex", int'(hex_value), 0);
    fv0 = dutFv; tm0 = dutTmo;
    applyStimulus(anOf(3), 7'h79, 8);
    applyStimulus(anOf(2), 7'h24, 8);
    applyStimulus(anOf(1), 7'h30, 8);
    applyStimulus(anOf(0), 7'h19, 8);
    applyStimulus(4'hF, 7'h7F, 12);
    checkOutput("t5_frames", dutFv - fv0, 1);
    checkOutput("t5_hex", int'(hex_value), 16'h1234);
    checkOutput("t5_timeouts", dutTmo - tm0, 0);

    $display("[TB] long dwell on digit 0");
    fv0 = dutFv; tm0 = dutTmo; cap0 = capCount[0];
    applyStimulus(anOf(3), 7'h12, 8);
    applyStimulus(anOf(2), 7'h02, 8);
    applyStimulus(anOf(1), 7'h78, 8);
    applyStimulus(anOf(0), 7'h30, 1000);
    applyStimulus(4'hF, 7'h7F, 20);
    checkOutput("t6_frames", dutFv - fv0, 1);
    checkOutput("t6_hex", int'(hex_value), 16'h5673);
    checkOutput("t6_timeouts", dutTmo - tm0, 0);
    checkOutput("t6_digit0_caps", capCount[0] - cap0, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
